// File: rtl/regbank_pkg.sv
// Shared types and default sizes for the register-bank controller.
// Imported by the controller top and its port mux.
package regbank_pkg;

  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_ADDR = 5;
  localparam int DEF_N_REGS  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR,
    ST_DUMP
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLEAR,
    OP_DUMP
  } op_t;

endpackage

// File: rtl/regbank_port_mux.sv
// Chooses who drives the bank write port and read port 1.
// Pipeline in IDLE/DRAIN; the sequencer in CLEAR/DUMP.
module regbank_port_mux
  import regbank_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_ADDR = DEF_NB_ADDR
) (
  input  state_t             state,
  input  logic               abort,
  input  logic               wb_en,
  input  logic [NB_ADDR-1:0] wb_addr,
  input  logic [NB_DATA-1:0] wb_data,
  input  logic [NB_ADDR-1:0] id_addr,
  input  logic [NB_ADDR-1:0] cnt,
  output logic               rb_we,
  output logic [NB_ADDR-1:0] rb_waddr,
  output logic [NB_DATA-1:0] rb_wdata,
  output logic [NB_ADDR-1:0] rb_raddr
);

  always_comb begin
    rb_we    = wb_en;
    rb_waddr = wb_addr;
    rb_wdata = wb_data;
    rb_raddr = id_addr;
    unique case (1'b1)
      // a reset edge landing mid-clear must not zero the addressed reg
      (state == ST_CLEAR): begin
        rb_we    = !abort;
        rb_waddr = cnt;
        rb_wdata = '0;
      end
      (state == ST_DUMP): begin
        rb_we    = 1'b0;
        rb_raddr = cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regbank_controller.sv
// Arbitrates the register bank between the pipeline and debug.
// Debug ops: CLEAR zeroes r1..rN-1, DUMP streams r0..rN-1.
module regbank_controller
  import regbank_pkg::*;
#(
  parameter int NB_DATA      = DEF_NB_DATA,
  parameter int NB_ADDR      = DEF_NB_ADDR,
  parameter int N_REGS       = DEF_N_REGS,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wb_write_enable,
  input  logic [NB_ADDR-1:0] i_wb_write_register,
  input  logic [NB_DATA-1:0] i_wb_write_data,
  input  logic [NB_ADDR-1:0] i_id_read_register_1,
  input  logic               i_clear_req,
  input  logic               i_dump_req,
  input  logic               i_dump_ready,
  input  logic [NB_DATA-1:0] i_rb_read_data_1,
  output logic               o_rb_write_enable,
  output logic [NB_ADDR-1:0] o_rb_write_register,
  output logic [NB_DATA-1:0] o_rb_write_data,
  output logic [NB_ADDR-1:0] o_rb_read_register_1,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_wb_dropped
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] LAST_D = DW'(DRAIN_CYCLES - 1);
  localparam logic [NB_ADDR-1:0] LAST = NB_ADDR'(N_REGS - 1);

  state_t             state;
  op_t                op;
  logic [NB_ADDR-1:0] cnt;
  logic [DW-1:0]      dcnt;
  logic               owned;

  assign owned = (state == ST_CLEAR) || (state == ST_DUMP);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      op           <= OP_NONE;
      cnt          <= '0;
      dcnt         <= '0;
      o_wb_dropped <= 1'b0;
    end else begin
      if (owned && i_wb_write_enable)
        o_wb_dropped <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          dcnt <= '0;
          if (i_clear_req) begin
            state <= ST_DRAIN;
            op    <= OP_CLEAR;
          end else if (i_dump_req) begin
            state <= ST_DRAIN;
            op    <= OP_DUMP;
          end
        end
        ST_DRAIN: begin
          if (dcnt == LAST_D) begin
            if (op == OP_CLEAR) begin
              state <= ST_CLEAR;
              cnt   <= NB_ADDR'(1);
            end else begin
              state <= ST_DUMP;
              cnt   <= '0;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
            op    <= OP_NONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + NB_ADDR'(1);
          end
        end
        ST_DUMP: begin
          if (i_dump_ready) begin
            if (cnt == LAST) begin
              state <= ST_IDLE;
              op    <= OP_NONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + NB_ADDR'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (state != ST_IDLE);
  assign o_stall      = o_busy;
  assign o_dump_valid = (state == ST_DUMP);
  assign o_dump_addr  = cnt;
  assign o_dump_data  = i_rb_read_data_1;

  regbank_port_mux #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_mux (
    .state    (state),
    .abort    (!i_reset),
    .wb_en    (i_wb_write_enable),
    .wb_addr  (i_wb_write_register),
    .wb_data  (i_wb_write_data),
    .id_addr  (i_id_read_register_1),
    .cnt      (cnt),
    .rb_we    (o_rb_write_enable),
    .rb_waddr (o_rb_write_register),
    .rb_wdata (o_rb_write_data),
    .rb_raddr (o_rb_read_register_1)
  );

endmodule

// File: tb/tb_regbank_controller.sv
// Bench for regbank_controller: bank model plus reference contents.
// Random data, directed sequences for clear/dump/reset.
module tb_regbank_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  id_rd;
  logic        clear_req;
  logic        dump_req;
  logic        dump_ready;
  logic [31:0] rd_data;
  logic        o_rb_write_enable;
  logic [4:0]  o_rb_write_register;
  logic [31:0] o_rb_write_data;
  logic [4:0]  o_rb_read_register_1;
  logic        o_dump_valid;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_stall;
  logic        o_busy;
  logic        o_wb_dropped;

  logic [31:0] bank [32];
  logic [31:0] refm [32];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (o_rb_write_enable) bank[o_rb_write_register] <= o_rb_write_data;

  assign rd_data = bank[o_rb_read_register_1];

  regbank_controller dut (
    .i_clk                (clk),
    .i_reset              (rst_n),
    .i_wb_write_enable    (wb_en),
    .i_wb_write_register  (wb_addr),
    .i_wb_write_data      (wb_data),
    .i_id_read_register_1 (id_rd),
    .i_clear_req          (clear_req),
    .i_dump_req           (dump_req),
    .i_dump_ready         (dump_ready),
    .i_rb_read_data_1     (rd_data),
    .o_rb_write_enable    (o_rb_write_enable),
    .o_rb_write_register  (o_rb_write_register),
    .o_rb_write_data      (o_rb_write_data),
    .o_rb_read_register_1 (o_rb_read_register_1),
    .o_dump_valid         (o_dump_valid),
    .o_dump_addr          (o_dump_addr),
    .o_dump_data          (o_dump_data),
    .o_stall              (o_stall),
    .o_busy               (o_busy),
    .o_wb_dropped         (o_wb_dropped)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input int a, input logic [31:0] d);
    logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    @(negedge clk);
    wb_en = 1'b1;
    wb_addr = 5'(a);
    wb_data = d;
    id_rd = r;
    #1;
    check("pt_we", o_rb_write_enable, 1);
    check("pt_waddr", o_rb_write_register, 32'(a));
    check("pt_wdata", o_rb_write_data, d);
    check("pt_raddr", o_rb_read_register_1, r);
    check("pt_stall", o_stall, 0);
    refm[a] = d;
  endtask

  task automatic wb_idle();
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic rd_check(input int a);
    @(negedge clk);
    wb_en = 1'b0;
    id_rd = 5'(a);
    #1;
    check("rd_addr", o_rb_read_register_1, 32'(a));
    check("rd_data", rd_data, refm[a]);
  endtask

  task automatic cmp_bank(input string tag);
    int bad = 0;
    for (int i = 0; i < 32; i++)
      if (bank[i] !== refm[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic do_clear(input bit both);
    int drain = 0, nwr = 0, bad = 0, dv = 0, after = 0;
    bit done = 0;
    @(negedge clk);
    wb_en = 1'b0;
    clear_req = 1'b1;
    dump_req = both;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
      dump_req = 1'b0;
      #1;
      if (c == 0) check("clr_stall_rise", o_stall, 1);
      if (!o_busy) begin
        done = 1;
        check("clr_stall_end", o_stall, 0);
      end else begin
        if (o_dump_valid) dv++;
        if (o_rb_write_enable) begin
          if (o_rb_write_register != 5'(nwr + 1) || o_rb_write_data != 0)
            bad++;
          nwr++;
          if (nwr == 10) dump_req = 1'b1;
        end else if (nwr == 0) drain++;
        else bad++;
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (o_busy || o_dump_valid) after++;
    end
    check("clr_done", done, 1);
    check("clr_drain", drain, 2);
    check("clr_writes", nwr, 31);
    check("clr_seq", bad, 0);
    check("clr_no_dump", dv, 0);
    check("clr_idle_after", after, 0);
    for (int i = 1; i < 32; i++) refm[i] = 0;
  endtask

  task automatic do_dump(input int mode, input bit inject);
    int n = 0, bad = 0, hold_bad = 0, drain = 0, wr_bad = 0;
    bit done = 0, pv = 0, pr = 0, rdy = 0, injected = 0;
    logic [4:0] pa = 0;
    logic [31:0] pd = 0;
    @(negedge clk);
    wb_en = 1'b0;
    dump_req = 1'b1;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      dump_req = 1'b0;
      wb_en = 1'b0;
      #1;
      if (c == 0) check("dmp_stall_rise", o_stall, 1);
      if (!o_busy) begin
        done = 1;
        check("dmp_valid_end", o_dump_valid, 0);
      end else if (!o_dump_valid) begin
        drain++;
      end else begin
        if (pv && !pr && (o_dump_addr !== pa || o_dump_data !== pd))
          hold_bad++;
        if (n > 31 || o_dump_addr !== 5'(n) || o_dump_data !== refm[n])
          bad++;
        if (o_rb_write_enable) wr_bad++;
        if (mode == 0) rdy = 1;
        else if (mode == 1) rdy = c[0];
        else rdy = 1'($urandom_range(0, 1));
        dump_ready = rdy;
        if (inject && n == 5 && !injected) begin
          injected = 1;
          wb_en = 1'b1;
          wb_addr = 5'd3;
          wb_data = 32'hAAAAAAAA;
          #1;
          check("drop_fwd", o_rb_write_enable, 0);
        end
        pv = 1;
        pr = rdy;
        pa = o_dump_addr;
        pd = o_dump_data;
        if (rdy) n++;
      end
    end
    dump_ready = 1'b0;
    wb_en = 1'b0;
    check("dmp_done", done, 1);
    check("dmp_drain", drain, 2);
    check("dmp_count", n, 32);
    check("dmp_words", bad, 0);
    check("dmp_hold", hold_bad, 0);
    check("dmp_nowrite", wr_bad, 0);
  endtask

  task automatic rst_mid();
    bit hit = 0;
    @(negedge clk);
    wb_en = 1'b0;
    clear_req = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      if (o_busy && o_rb_write_enable && o_rb_write_register == 5'd10) begin
        hit = 1;
        rst_n = 1'b0;
      end
    end
    check("rst_hit", hit, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_stall", o_stall, 0);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_dump_valid, 0);
    check("rst_dropped", o_wb_dropped, 0);
    for (int i = 1; i < 10; i++) refm[i] = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_en = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    id_rd = '0;
    clear_req = 1'b0;
    dump_req = 1'b0;
    dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", o_stall, 0);
    check("reset_busy", o_busy, 0);
    check("reset_valid", o_dump_valid, 0);
    check("reset_dropped", o_wb_dropped, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) wb_write(i, $urandom);
    wb_write(5, 32'h55555555);
    rd_check(5);
    wb_write(1, 32'h11111111);
    wb_write(31, 32'hFFFFFFFF);
    wb_idle();
    do_clear(0);
    cmp_bank("clr_bank");
    rd_check(1);
    rd_check(31);
    rd_check(0);

    for (int i = 0; i < 8; i++)
      wb_write($urandom_range(1, 31), $urandom);
    wb_write(2, 32'h22222222);
    wb_write(3, $urandom);
    wb_idle();
    do_dump(1, 1);
    check("drop_sticky", o_wb_dropped, 1);
    cmp_bank("dmp_bank");
    rd_check(3);
    do_dump(2, 0);
    do_dump(0, 0);
    check("drop_hold", o_wb_dropped, 1);

    do_clear(1);
    cmp_bank("clr2_bank");

    for (int i = 1; i < 32; i++) wb_write(i, $urandom | 32'h1);
    wb_idle();
    check("drop_pre_rst", o_wb_dropped, 1);
    rst_mid();
    cmp_bank("rst_bank");
    wb_write(7, 32'h0BADF00D);
    rd_check(7);
    rd_check(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
